// File: rtl/chiplet_types_pkg.sv
// ---------------------------------------------------------------------------
// chiplet_types_pkg
//
// Types and helpers shared between the endpoint transmit and receive paths.
//
// Contents:
//   flit_t              32-bit flit; on a header flit, total_len carries the
//                       packet's total byte count including header and CRC.
//   PKT_LENGTH_WIDTH    width of a packet length expressed in flits.
//   expected_num_flits  header flit -> total number of flits in the packet.
//   tx_state_e          transmit sequencer state, visible to monitors.
// ---------------------------------------------------------------------------
package chiplet_types_pkg;

  // A 16-bit byte count rounds up to at most 16384 flits, which needs 15 bits.
  localparam int PKT_LENGTH_WIDTH = 15;

  typedef struct packed {
    logic [7:0]  kind;
    logic [7:0]  tag;
    logic [15:0] total_len;
  } flit_t;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } tx_state_e;

  // Flits carry 4 bytes each, so the flit count is the byte count rounded up
  // to a multiple of 4 and divided by 4. The sum is widened by one bit so a
  // byte count near 16'hFFFF does not wrap before the shift.
  function automatic logic [PKT_LENGTH_WIDTH-1:0] expected_num_flits(input flit_t hdr);
    logic [16:0] rounded;
    rounded = {1'b0, hdr.total_len} + 17'd3;
    return rounded[16:2];
  endfunction

endpackage

// File: rtl/tx_credit_counter.sv
// ---------------------------------------------------------------------------
// tx_credit_counter
//
// Tracks free slots in the switch input buffer. A flit sent consumes one
// credit, a credit_return pulse gives one back. The count starts full.
//
// Ports:
//   clk            system clock, posedge
//   rst            synchronous active-high reset
//   consume        a flit leaves this cycle
//   credit_return  the switch freed one slot this cycle
//   credits        current credit count
//   has_credit     credits != 0
//   credit_err     sticky: a return arrived while the count was already full
// ---------------------------------------------------------------------------
module tx_credit_counter #(
  parameter int CREDITS      = 8,
  parameter int CREDIT_WIDTH = $clog2(CREDITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    consume,
  input  logic                    credit_return,
  output logic [CREDIT_WIDTH-1:0] credits,
  output logic                    has_credit,
  output logic                    credit_err
);

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(CREDITS);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE = CREDIT_WIDTH'(1);

  logic [CREDIT_WIDTH-1:0] credits_d;
  logic [CREDIT_WIDTH-1:0] credits_q;
  logic                    credit_err_d;
  logic                    credit_err_q;

  // A send and a return in the same cycle cancel out. A return into a full
  // counter means the switch and this endpoint disagree about buffer depth;
  // the count is held at its maximum and the disagreement is flagged.
  // consume is never asserted at zero credits because sending needs
  // has_credit, so the decrement cannot underflow.
  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    if (consume && !credit_return) begin
      credits_d = credits_q - CREDIT_ONE;
    end else if (!consume && credit_return) begin
      if (credits_q == CREDIT_MAX) begin
        credit_err_d = 1'b1;
      end else begin
        credits_d = credits_q + CREDIT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q    <= CREDIT_MAX;
      credit_err_q <= 1'b0;
    end else begin
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign credits    = credits_q;
  assign has_credit = (credits_q != '0);
  assign credit_err = credit_err_q;

endmodule

// File: rtl/tx_fsm.sv
// ---------------------------------------------------------------------------
// tx_fsm
//
// Endpoint transmit sequencer. Drains whole packets from the show-ahead TX
// flit FIFO into switch input port 0 under credit-based flow control. The
// header flit's total length is decoded with expected_num_flits() so packet
// framing matches what the receive side counts.
//
// Ports:
//   clk            system clock, posedge
//   rst            synchronous active-high reset
//   enable         permits starting a new packet (ignored mid-packet)
//   fifo_rdata     head flit of the TX FIFO (show-ahead)
//   fifo_empty     TX FIFO empty
//   fifo_ren       pop the TX FIFO (same as data_ready_in)
//   out_flit       flit presented to the switch (always fifo_rdata)
//   data_ready_in  out_flit valid and consumed this cycle
//   credit_return  switch freed one buffer slot
//   credits        current credit count
//   busy           a packet is in flight
//   pkt_done       pulse in the cycle the final flit of a packet is sent
//   pkt_count      packets completed since reset (wraps)
//   length_err     sticky: a header decoded to fewer than 2 flits
//   credit_err     sticky: credit returned while credits were full
// ---------------------------------------------------------------------------
module tx_fsm
  import chiplet_types_pkg::*;
#(
  parameter int CREDITS       = 8,
  parameter int CREDIT_WIDTH  = $clog2(CREDITS + 1),
  parameter int PKT_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  flit_t                    fifo_rdata,
  input  logic                     fifo_empty,
  output logic                     fifo_ren,
  output flit_t                    out_flit,
  output logic                     data_ready_in,
  input  logic                     credit_return,
  output logic [CREDIT_WIDTH-1:0]  credits,
  output logic                     busy,
  output logic                     pkt_done,
  output logic [PKT_CNT_WIDTH-1:0] pkt_count,
  output logic                     length_err,
  output logic                     credit_err
);

  localparam logic [PKT_LENGTH_WIDTH-1:0] LEN_ONE = PKT_LENGTH_WIDTH'(1);
  localparam logic [PKT_LENGTH_WIDTH-1:0] LEN_TWO = PKT_LENGTH_WIDTH'(2);
  localparam logic [PKT_CNT_WIDTH-1:0]    CNT_ONE = PKT_CNT_WIDTH'(1);

  tx_state_e                  state_d;
  tx_state_e                  state_q;
  logic [PKT_LENGTH_WIDTH-1:0] remaining_d;
  logic [PKT_LENGTH_WIDTH-1:0] remaining_q;
  logic [PKT_CNT_WIDTH-1:0]    pkt_count_d;
  logic [PKT_CNT_WIDTH-1:0]    pkt_count_q;
  logic                        length_err_d;
  logic                        length_err_q;

  logic [PKT_LENGTH_WIDTH-1:0] hdr_len;
  logic                        can_send;
  logic                        has_credit;
  logic                        send;

  // Only meaningful while in IDLE, when fifo_rdata is a header flit.
  assign hdr_len = expected_num_flits(fifo_rdata);

  // The flit path is purely combinational: the head of the FIFO is offered
  // to the switch directly and popped in the same cycle it is accepted.
  // Holding reset suppresses sending so nothing leaves while the sequencer
  // and credit counter are being re-initialised.
  always_comb begin
    can_send = ((state_q == IDLE) && enable) || (state_q == BODY);
    send     = !rst && can_send && !fifo_empty && has_credit;
  end

  tx_credit_counter #(
    .CREDITS      (CREDITS),
    .CREDIT_WIDTH (CREDIT_WIDTH)
  ) u_credit_counter (
    .clk           (clk),
    .rst           (rst),
    .consume       (send),
    .credit_return (credit_return),
    .credits       (credits),
    .has_credit    (has_credit),
    .credit_err    (credit_err)
  );

  // Next-state logic. In IDLE a send is always a header; remaining then
  // counts the flits still owed after the header, so the flit sent while
  // remaining == 1 is the CRC flit that closes the packet. A header claiming
  // fewer than 2 flits cannot carry a CRC; it is treated as a complete
  // header-only packet and flagged, so the FIFO never desynchronises.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    pkt_count_d  = pkt_count_q;
    length_err_d = length_err_q;
    pkt_done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (send) begin
          if (hdr_len >= LEN_TWO) begin
            remaining_d = hdr_len - LEN_ONE;
            state_d     = BODY;
          end else begin
            length_err_d = 1'b1;
            pkt_done     = 1'b1;
            pkt_count_d  = pkt_count_q + CNT_ONE;
          end
        end
      end

      BODY: begin
        if (send) begin
          remaining_d = remaining_q - LEN_ONE;
          if (remaining_q == LEN_ONE) begin
            pkt_done    = 1'b1;
            pkt_count_d = pkt_count_q + CNT_ONE;
            state_d     = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset abandons any packet in flight without reporting it as done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      pkt_count_q  <= '0;
      length_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      pkt_count_q  <= pkt_count_d;
      length_err_q <= length_err_d;
    end
  end

  assign fifo_ren      = send;
  assign data_ready_in = send;
  assign out_flit      = fifo_rdata;
  assign busy          = (state_q == BODY);
  assign pkt_count     = pkt_count_q;
  assign length_err    = length_err_q;

endmodule

// File: tb/tb_tx_fsm.sv
// ---------------------------------------------------------------------------
// tb_tx_fsm
//
// Directed bench for tx_fsm with CREDITS=8. A small array-based show-ahead
// FIFO feeds the DUT. Credits are drawn down by earlier scenarios to reach
// the low-credit starting points later scenarios need.
// ---------------------------------------------------------------------------
module tb_tx_fsm;
  import chiplet_types_pkg::*;

  localparam int CREDITS = 8;
  localparam int CW      = $clog2(CREDITS + 1);
  localparam int PCW     = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  flit_t          fifo_rdata;
  logic           fifo_empty;
  logic           fifo_ren;
  flit_t          out_flit;
  logic           data_ready_in;
  logic           credit_return;
  logic [CW-1:0]  credits;
  logic           busy;
  logic           pkt_done;
  logic [PCW-1:0] pkt_count;
  logic           length_err;
  logic           credit_err;

  flit_t      fifo_mem [0:255];
  logic [7:0] rd_ptr = 8'd0;
  logic [7:0] wr_ptr = 8'd0;
  logic       flush;

  int    checks = 0;
  int    passes = 0;
  flit_t exp_flit;

  always #5 clk = ~clk;

  tx_fsm #(
    .CREDITS       (CREDITS),
    .CREDIT_WIDTH  (CW),
    .PKT_CNT_WIDTH (PCW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .fifo_rdata    (fifo_rdata),
    .fifo_empty    (fifo_empty),
    .fifo_ren      (fifo_ren),
    .out_flit      (out_flit),
    .data_ready_in (data_ready_in),
    .credit_return (credit_return),
    .credits       (credits),
    .busy          (busy),
    .pkt_done      (pkt_done),
    .pkt_count     (pkt_count),
    .length_err    (length_err),
    .credit_err    (credit_err)
  );

  // Show-ahead FIFO model: the head entry is always visible, a pop advances
  // the read pointer at the clock edge.
  assign fifo_rdata = fifo_mem[rd_ptr];
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_ren) rd_ptr <= rd_ptr + 8'd1;
  end

  function automatic flit_t hdr_flit(input logic [7:0] tag, input logic [15:0] total_len);
    flit_t f;
    f.kind = 8'hA0; f.tag = tag; f.total_len = total_len;
    return f;
  endfunction

  function automatic flit_t body_flit(input logic [7:0] tag, input int idx);
    flit_t f;
    f.kind = 8'hD0; f.tag = tag; f.total_len = 16'(idx);
    return f;
  endfunction

  task automatic push_flit(input flit_t f);
    fifo_mem[wr_ptr] = f;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic push_packet(input logic [7:0] tag, input logic [15:0] total_len, input int nflits);
    push_flit(hdr_flit(tag, total_len));
    for (int k = 1; k < nflits; k++) push_flit(body_flit(tag, k));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset, then idle with an empty FIFO for 10 cycles.
  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; credit_return = 1'b0; flush = 1'b1;
    step(); step();
    rst = 1'b0; flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (credits !== 4'd8 || data_ready_in !== 1'b0 || pkt_count !== 16'd0 || busy !== 1'b0)
        $display("[TB] FAIL reset_idle cyc%0d: got credits=%0d dri=%b cnt=%0d busy=%b, want 8 0 0 0",
                 i, credits, data_ready_in, pkt_count, busy);
      else passes++;
      step();
    end
  endtask

  // One 4-flit packet (16 bytes) with full credits.
  task automatic test_single_packet();
    push_packet(8'h01, 16'd16, 4);
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_flit = (i == 0) ? hdr_flit(8'h01, 16'd16) : body_flit(8'h01, i);
      checks++;
      if (data_ready_in !== 1'b1 || out_flit !== exp_flit || pkt_done !== (i == 3))
        $display("[TB] FAIL single cyc%0d: got dri=%b flit=%h done=%b, want 1 %h %b",
                 i, data_ready_in, out_flit, pkt_done, exp_flit, (i == 3));
      else passes++;
      step();
      checks++;
      if (credits !== 4'(7 - i))
        $display("[TB] FAIL single_credits cyc%0d: got %0d want %0d", i, credits, 7 - i);
      else passes++;
    end
    #1;
    checks++;
    if (data_ready_in !== 1'b0 || pkt_count !== 16'd1 || busy !== 1'b0)
      $display("[TB] FAIL single_end: got dri=%b cnt=%0d busy=%b, want 0 1 0",
               data_ready_in, pkt_count, busy);
    else passes++;
    credit_return = 1'b1;
    for (int i = 0; i < 4; i++) step();
    credit_return = 1'b0;
    #1;
    checks++;
    if (credits !== 4'd8 || credit_err !== 1'b0)
      $display("[TB] FAIL single_refill: got credits=%0d cerr=%b, want 8 0", credits, credit_err);
    else passes++;
  endtask

  // Drain to 2 credits with a 6-flit packet, then a 5-flit packet starves.
  task automatic test_credit_starvation();
    push_packet(8'h02, 16'd24, 6);
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (data_ready_in !== 1'b1 || pkt_done !== (i == 5))
        $display("[TB] FAIL drain cyc%0d: got dri=%b done=%b, want 1 %b", i, data_ready_in, pkt_done, (i == 5));
      else passes++;
      step();
    end
    checks++;
    if (credits !== 4'd2 || pkt_count !== 16'd2)
      $display("[TB] FAIL drain_end: got credits=%0d cnt=%0d, want 2 2", credits, pkt_count);
    else passes++;

    push_packet(8'h03, 16'd20, 5);
    for (int i = 0; i < 2; i++) begin
      #1;
      exp_flit = (i == 0) ? hdr_flit(8'h03, 16'd20) : body_flit(8'h03, i);
      checks++;
      if (data_ready_in !== 1'b1 || out_flit !== exp_flit)
        $display("[TB] FAIL starve_send cyc%0d: got dri=%b flit=%h, want 1 %h", i, data_ready_in, out_flit, exp_flit);
      else passes++;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (data_ready_in !== 1'b0 || busy !== 1'b1 || credits !== 4'd0)
        $display("[TB] FAIL starve_stall cyc%0d: got dri=%b busy=%b credits=%0d, want 0 1 0",
                 i, data_ready_in, busy, credits);
      else passes++;
      step();
    end
    for (int p = 0; p < 3; p++) begin
      credit_return = 1'b1;
      #1;
      checks++;
      if (data_ready_in !== 1'b0)
        $display("[TB] FAIL starve_pulse%0d: got dri=%b want 0", p, data_ready_in);
      else passes++;
      step();
      credit_return = 1'b0;
      #1;
      exp_flit = body_flit(8'h03, 2 + p);
      checks++;
      if (data_ready_in !== 1'b1 || out_flit !== exp_flit || pkt_done !== (p == 2))
        $display("[TB] FAIL starve_resume%0d: got dri=%b flit=%h done=%b, want 1 %h %b",
                 p, data_ready_in, out_flit, pkt_done, exp_flit, (p == 2));
      else passes++;
      step();
    end
    checks++;
    if (credits !== 4'd0 || busy !== 1'b0 || pkt_count !== 16'd3)
      $display("[TB] FAIL starve_end: got credits=%0d busy=%b cnt=%0d, want 0 0 3", credits, busy, pkt_count);
    else passes++;
  endtask

  // One credit, return pulse every cycle: 6 flits go out without a stall.
  task automatic test_simultaneous();
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    push_packet(8'h04, 16'd21, 6);
    for (int i = 0; i < 6; i++) begin
      credit_return = 1'b1;
      #1;
      exp_flit = (i == 0) ? hdr_flit(8'h04, 16'd21) : body_flit(8'h04, i);
      checks++;
      if (data_ready_in !== 1'b1 || out_flit !== exp_flit || pkt_done !== (i == 5))
        $display("[TB] FAIL simul cyc%0d: got dri=%b flit=%h done=%b, want 1 %h %b",
                 i, data_ready_in, out_flit, pkt_done, exp_flit, (i == 5));
      else passes++;
      step();
      checks++;
      if (credits !== 4'd1)
        $display("[TB] FAIL simul_credits cyc%0d: got %0d want 1", i, credits);
      else passes++;
    end
    credit_return = 1'b0;
    #1;
    checks++;
    if (pkt_count !== 16'd4 || busy !== 1'b0)
      $display("[TB] FAIL simul_end: got cnt=%0d busy=%b, want 4 0", pkt_count, busy);
    else passes++;
    credit_return = 1'b1;
    for (int i = 0; i < 7; i++) step();
    credit_return = 1'b0;
    #1;
    checks++;
    if (credits !== 4'd8 || credit_err !== 1'b0)
      $display("[TB] FAIL simul_refill: got credits=%0d cerr=%b, want 8 0", credits, credit_err);
    else passes++;
  endtask

  // 2-flit then 3-flit packet with no gap; enable drops during packet 2.
  task automatic test_back_to_back();
    push_packet(8'h05, 16'd5, 2);
    push_packet(8'h06, 16'd12, 3);
    for (int i = 0; i < 5; i++) begin
      enable = (i < 3);
      #1;
      case (i)
        0: exp_flit = hdr_flit(8'h05, 16'd5);
        1: exp_flit = body_flit(8'h05, 1);
        2: exp_flit = hdr_flit(8'h06, 16'd12);
        3: exp_flit = body_flit(8'h06, 1);
        default: exp_flit = body_flit(8'h06, 2);
      endcase
      checks++;
      if (data_ready_in !== 1'b1 || out_flit !== exp_flit || pkt_done !== (i == 1 || i == 4))
        $display("[TB] FAIL b2b cyc%0d: got dri=%b flit=%h done=%b, want 1 %h %b",
                 i, data_ready_in, out_flit, pkt_done, exp_flit, (i == 1 || i == 4));
      else passes++;
      step();
    end
    checks++;
    if (pkt_count !== 16'd6 || credits !== 4'd3 || busy !== 1'b0)
      $display("[TB] FAIL b2b_end: got cnt=%0d credits=%0d busy=%b, want 6 3 0", pkt_count, credits, busy);
    else passes++;
    push_packet(8'h07, 16'd4, 1);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (data_ready_in !== 1'b0 || busy !== 1'b0)
        $display("[TB] FAIL enable_block cyc%0d: got dri=%b busy=%b, want 0 0", i, data_ready_in, busy);
      else passes++;
      step();
    end
  endtask

  // A header decoding to 1 flit is sent alone and flagged.
  task automatic test_length_error();
    enable = 1'b1;
    #1;
    exp_flit = hdr_flit(8'h07, 16'd4);
    checks++;
    if (data_ready_in !== 1'b1 || out_flit !== exp_flit || pkt_done !== 1'b1)
      $display("[TB] FAIL len1_send: got dri=%b flit=%h done=%b, want 1 %h 1",
               data_ready_in, out_flit, pkt_done, exp_flit);
    else passes++;
    step();
    checks++;
    if (length_err !== 1'b1 || busy !== 1'b0 || pkt_count !== 16'd7 || credits !== 4'd2)
      $display("[TB] FAIL len1_after: got lerr=%b busy=%b cnt=%0d credits=%0d, want 1 0 7 2",
               length_err, busy, pkt_count, credits);
    else passes++;
  endtask

  // Refill to the maximum, then one extra return.
  task automatic test_credit_error();
    credit_return = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (credits !== 4'd8 || credit_err !== 1'b0)
      $display("[TB] FAIL cerr_full: got credits=%0d cerr=%b, want 8 0", credits, credit_err);
    else passes++;
    step();
    credit_return = 1'b0;
    checks++;
    if (credits !== 4'd8 || credit_err !== 1'b1)
      $display("[TB] FAIL cerr_over: got credits=%0d cerr=%b, want 8 1", credits, credit_err);
    else passes++;
  endtask

  // Reset while mid-body: packet abandoned, state and flags cleared.
  task automatic test_reset_mid_body();
    push_packet(8'h08, 16'd16, 4);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (data_ready_in !== 1'b1)
        $display("[TB] FAIL rstmid_send cyc%0d: got dri=%b want 1", i, data_ready_in);
      else passes++;
      step();
    end
    rst = 1'b1;
    #1;
    checks++;
    if (data_ready_in !== 1'b0 || fifo_ren !== 1'b0 || pkt_done !== 1'b0 || busy !== 1'b1)
      $display("[TB] FAIL rstmid_held: got dri=%b ren=%b done=%b busy=%b, want 0 0 0 1",
               data_ready_in, fifo_ren, pkt_done, busy);
    else passes++;
    step();
    checks++;
    if (busy !== 1'b0 || credits !== 4'd8 || length_err !== 1'b0 || credit_err !== 1'b0 || pkt_count !== 16'd0)
      $display("[TB] FAIL rstmid_after: got busy=%b credits=%0d lerr=%b cerr=%b cnt=%0d, want 0 8 0 0 0",
               busy, credits, length_err, credit_err, pkt_count);
    else passes++;
    flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (data_ready_in !== 1'b0 || pkt_done !== 1'b0)
      $display("[TB] FAIL rstmid_idle: got dri=%b done=%b, want 0 0", data_ready_in, pkt_done);
    else passes++;
    step();
  endtask

  initial begin
    $display("[TB] tx_fsm directed test start");
    test_reset();
    test_single_packet();
    test_credit_starvation();
    test_simultaneous();
    test_back_to_back();
    test_length_error();
    test_credit_error();
    test_reset_mid_body();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
